// File: rtl/vnu_3.sv
// vnu_3: min-sum LDPC variable-node update, 3 check edges, fixed iteration budget
// Ports: clk, rst (async, active-low), cnt (shared 16-slot schedule),
//   ch_valid/LLR_ch (channel LLR load at LOAD_SLOT), C2V_1..3 (sampled at UPD_SLOT),
//   V2C_1..3 (registered extrinsic messages), hard_dec (total LLR < 0),
//   iter_num (completed updates this frame), done (sticky budget-reached flag).
module vnu_3 #(
  parameter logic [3:0] LOAD_SLOT = 4'd0,
  parameter logic [3:0] UPD_SLOT  = 4'd8,
  parameter logic [3:0] MAX_ITER  = 4'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cnt,
  input  logic       ch_valid,
  input  logic [9:0] LLR_ch,
  input  logic [9:0] C2V_1,
  input  logic [9:0] C2V_2,
  input  logic [9:0] C2V_3,
  output logic [9:0] V2C_1,
  output logic [9:0] V2C_2,
  output logic [9:0] V2C_3,
  output logic       hard_dec,
  output logic [3:0] iter_num,
  output logic       done
);
  logic [9:0] llr_reg, c_reg1, c_reg2, c_reg3;
  logic [11:0] sum_reg, sum_nxt;
  logic active, upd_pend, load, capture;
  logic [9:0] v_load, v1_nxt, v2_nxt, v3_nxt;
  logic [3:0] iter_inc;
  // symmetric clip to [-511, +511]; -512 is never produced
  function automatic logic [9:0] sat(input logic signed [12:0] x);
    return x > 13'sd511 ? 10'sd511 : x < -13'sd511 ? -10'sd511 : x[9:0];
  endfunction
  function automatic logic [11:0] sx12(input logic [9:0] x);
    return {{2{x[9]}}, x};
  endfunction
  function automatic logic [12:0] sx13(input logic [9:0] x);
    return {{3{x[9]}}, x};
  endfunction
  always_comb begin
    load     = cnt == LOAD_SLOT && ch_valid;
    capture  = cnt == UPD_SLOT && active;
    sum_nxt  = sx12(llr_reg) + sx12(C2V_1) + sx12(C2V_2) + sx12(C2V_3);
    v_load   = sat(sx13(LLR_ch));
    // extrinsic message: total minus the edge's own contribution
    v1_nxt   = sat({sum_reg[11], sum_reg} - sx13(c_reg1));
    v2_nxt   = sat({sum_reg[11], sum_reg} - sx13(c_reg2));
    v3_nxt   = sat({sum_reg[11], sum_reg} - sx13(c_reg3));
    iter_inc = iter_num + 4'd1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      llr_reg  <= '0;
      c_reg1   <= '0;
      c_reg2   <= '0;
      c_reg3   <= '0;
      sum_reg  <= '0;
      active   <= 1'b0;
      upd_pend <= 1'b0;
      V2C_1    <= '0;
      V2C_2    <= '0;
      V2C_3    <= '0;
      hard_dec <= 1'b0;
      iter_num <= '0;
      done     <= 1'b0;
    end else if (load) begin
      llr_reg  <= LLR_ch;
      V2C_1    <= v_load;
      V2C_2    <= v_load;
      V2C_3    <= v_load;
      hard_dec <= LLR_ch[9];
      iter_num <= '0;
      done     <= 1'b0;
      active   <= 1'b1;
      upd_pend <= 1'b0;
    end else begin
      if (capture) begin
        c_reg1   <= C2V_1;
        c_reg2   <= C2V_2;
        c_reg3   <= C2V_3;
        sum_reg  <= sum_nxt;
        upd_pend <= 1'b1;
      end
      if (upd_pend) begin
        V2C_1    <= v1_nxt;
        V2C_2    <= v2_nxt;
        V2C_3    <= v3_nxt;
        hard_dec <= sum_reg[11];
        iter_num <= iter_inc;
        upd_pend <= 1'b0;
        if (iter_inc == MAX_ITER) begin
          done   <= 1'b1;
          active <= 1'b0;
        end
      end
    end
  end
endmodule

// File: doc/vnu_3.md
# vnu_3

Variable-node update unit for the min-sum LDPC decoder. It sits at the opposite end of the V2C/C2V exchange from the check-node unit. Per iteration it combines the stored channel LLR with three incoming C2V messages and produces three extrinsic V2C messages and a hard decision. It shares the 16-slot `cnt` schedule counter with the CNU array and stops after a fixed iteration budget.

## Interface
Parameters:
- `LOAD_SLOT`, default 4'd0: `cnt` value at which a new channel LLR is accepted.
- `UPD_SLOT`, default 4'd8: `cnt` value at which C2V messages are sampled. Constraints: must differ from `LOAD_SLOT`, must not equal 4'd15, and `UPD_SLOT+1` must differ from `LOAD_SLOT`.
- `MAX_ITER`, default 4'd4: number of updates per frame, range 1..15.

Ports:
- `clk`, in, 1: clock. All registers update on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `cnt`, in, 4: shared schedule slot, 0..15, wraps.
- `ch_valid`, in, 1: channel LLR valid. Only meaningful when `cnt==LOAD_SLOT`.
- `LLR_ch`, in, 10: channel LLR, signed two's complement.
- `C2V_1`..`C2V_3`, in, 10 each: check-to-variable messages, signed.
- `V2C_1`..`V2C_3`, out, 10 each: variable-to-check messages, signed, registered.
- `hard_dec`, out, 1: hard decision. 1 means the total LLR is negative.
- `iter_num`, out, 4: number of completed updates in the current frame.
- `done`, out, 1: sticky flag, set when `iter_num` reaches `MAX_ITER`.

## Operation
- Internal state:
  - `llr_reg` (10b)
  - `c_reg1..3` (10b)
  - `sum_reg` (12b)
  - `active` (1b)
  - `upd_pend` (1b)
- **Reset** (`rst`=0, asynchronous): every register and every output clears to 0, `active`=0, `upd_pend`=0.
- **LOAD**, on an edge with `cnt==LOAD_SLOT` and `ch_valid`=1:
  - `llr_reg`←`LLR_ch`.
  - Each `V2C_i`←sat(`LLR_ch`), so first-iteration messages are the channel LLR.
  - `hard_dec`←`LLR_ch[9]`.
  - `iter_num`←0, `done`←0, `active`←1, `upd_pend`←0.
  - A load while `active`=1 aborts the current frame and restarts.
  - `ch_valid` is ignored in every other slot.
- **CAPTURE**, on an edge with `cnt==UPD_SLOT` and `active`=1:
  - `c_reg_i`←`C2V_i`.
  - `sum_reg`←sext12(`llr_reg`)+Σ sext12(`C2V_i`). The range is ±2048, so 12 bits does not overflow.
  - `upd_pend`←1.
- **EMIT**, on the next edge (`upd_pend`=1):
  - Each `V2C_i`←sat(sext13(`sum_reg`) − sext13(`c_reg_i`)).
  - `hard_dec`←`sum_reg[11]`.
  - `iter_num`←`iter_num`+1.
  - `upd_pend`←0.
  - If `iter_num`+1 == `MAX_ITER`: `done`←1 and `active`←0.
- **Saturation** sat(): symmetric clip to [−511, +511].
  - −512 is never emitted, including on LOAD with `LLR_ch`=−512.
- **Idle**: when `active`=0, `UPD_SLOT` is ignored and all outputs hold.
- `done` and the final `V2C`/`hard_dec` values hold until the next LOAD or reset.

## Timing
- LOAD → outputs valid 1 cycle after the edge at `cnt==LOAD_SLOT`.
- C2V must be stable at the edge where `cnt==UPD_SLOT`. Values on other cycles are don't-care.
- Update latency: 2 edges.
  - `V2C`, `hard_dec`, `iter_num` and `done` change together at the edge where `cnt==UPD_SLOT+1`.
  - They are visible during slot `UPD_SLOT+2`.
- One update per 16-cycle `cnt` period. A frame with `MAX_ITER`=4 completes 4 periods after the load.
- `V2C` outputs are stable from one EMIT (or LOAD) to the next. The CNU may sample them in any slot outside the EMIT edge.
- Reset mid-frame (async): outputs clear immediately. No update occurs until a new LOAD.
- `cnt` wrap (15→0): no special behaviour. Slots are pure compares.

## Test plan
- **Reset**: `rst`=0 mid-frame with `V2C_1`=19 → all outputs 0 immediately. `done` stays 0 through the next full `cnt` period.
- **Load + basic update**: `LLR_ch`=20 at slot 0 → `V2C`=20,20,20, `hard_dec`=0. Then C2V=−8, 9, −10 at slot 8 → at the edge with `cnt`=9: `V2C`=19, 2, 21, `hard_dec`=0, `iter_num`=1.
- **Positive saturation**: `LLR_ch`=500, C2V=400 each → `sum_reg`=1700, `V2C`=511 each, `hard_dec`=0.
- **Negative saturation and load clip**: `LLR_ch`=−512 → `V2C`=−511 each. Then C2V=−512 each → `sum_reg`=−2048, `V2C`=−511 each, `hard_dec`=1.
- **Iteration budget**, `MAX_ITER`=4: constant C2V=1, 1, 1 with `LLR_ch`=−5.
  - Each update gives `V2C`=−3 each and `hard_dec`=1.
  - After the 4th EMIT: `done`=1, `iter_num`=4.
  - In the 5th period, C2V=100 changes nothing.
- **Abort / ignore**:
  - `ch_valid`=1 at slot 3 → ignored.
  - A reload at slot 0 after 2 iterations with `LLR_ch`=7 → `iter_num`=0, `done`=0, `V2C`=7 each, and the frame restarts.
